// File: rtl/queue_serializer_if.sv
// queue_serializer_if: queue-side (len/data/dequeue) and sink-side (bit/valid/ready/flags) signals.
interface queue_serializer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4
);
   logic                  enable_in;
   logic [LEN_WIDTH-1:0]  len_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  dequeue_out;
   logic                  bit_out;
   logic                  bit_valid_out;
   logic                  ready_in;
   logic                  first_bit_out;
   logic                  last_bit_out;
   logic                  busy_out;
   logic [7:0]            frames_out;
   modport master (
      output enable_in, len_in, data_in, ready_in,
      input  dequeue_out, bit_out, bit_valid_out, first_bit_out, last_bit_out, busy_out, frames_out
   );
   modport slave (
      input  enable_in, len_in, data_in, ready_in,
      output dequeue_out, bit_out, bit_valid_out, first_bit_out, last_bit_out, busy_out, frames_out
   );
endinterface

// File: rtl/queue_serializer.sv
// queue_serializer: pops bytes from the queue head and shifts them out MSB-first over a valid/ready bit link.
module queue_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4,
   parameter int GAP_CYCLES = 1
) (
   input logic          clock,
   input logic          reset,
   queue_serializer_if.slave q
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2:0]            gap_q, gap_d;
   logic                  deq_q, deq_d;
   logic [7:0]            frames_q, frames_d;
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         gap_q    <= '0;
         deq_q    <= 1'b0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         deq_q    <= deq_d;
         frames_q <= frames_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      deq_d    = 1'b0;
      frames_d = frames_q;
      case (state_q)
         IDLE: if (q.enable_in && q.len_in != '0) begin
            state_d = SHIFT;
            shift_d = q.data_in;
            cnt_d   = CW'(DATA_WIDTH - 1);
            deq_d   = 1'b1;
         end
         SHIFT: if (q.ready_in) begin
            shift_d = shift_q << 1;
            if (cnt_q == '0) begin
               state_d  = GAP;
               frames_d = frames_q + 8'd1;
               gap_d    = 3'(GAP_CYCLES - 1);
            end else
               cnt_d = cnt_q - CW'(1);
         end
         GAP: begin
            gap_d   = (gap_q == '0) ? gap_q : gap_q - 3'd1;
            state_d = (gap_q == '0) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
   end
   // Only SHIFT drives the link; flags are gated so GAP/IDLE show all zeros.
   assign q.dequeue_out   = deq_q;
   assign q.bit_valid_out = (state_q == SHIFT);
   assign q.bit_out       = q.bit_valid_out & shift_q[DATA_WIDTH-1];
   assign q.first_bit_out = q.bit_valid_out && (cnt_q == CW'(DATA_WIDTH - 1));
   assign q.last_bit_out  = q.bit_valid_out && (cnt_q == '0);
   assign q.busy_out      = (state_q != IDLE);
   assign q.frames_out    = frames_q;
endmodule

// File: tb/tb_queue_serializer.sv
// tb_queue_serializer: directed and random frames checked against a byte-queue / bit-stream reference model.
module tb_queue_serializer;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;
   queue_serializer_if bus ();
   queue_serializer dut (.clock(clock), .reset(reset), .q(bus));
   int vectors = 0, miscompares = 0;
   logic [7:0] q_model[$];
   logic [7:0] sent[$];
   int deq_cyc[$];
   logic [7:0] acc;
   logic [63:0] stream;
   logic pending;
   int nbits, frames_exp, cyc, deq_cnt, valid_cycles, busy_cycles;
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic refresh();
      bus.len_in  = 4'(q_model.size());
      bus.data_in = (q_model.size() != 0) ? q_model[0] : 8'h00;
   endtask
   task automatic push(logic [7:0] b);
      q_model.push_back(b);
      refresh();
   endtask
   task automatic clear_stats();
      deq_cnt = 0;
      valid_cycles = 0;
      busy_cycles = 0;
      stream = '0;
      deq_cyc.delete();
   endtask
   // Observe the link before the edge, then advance the reference model by what that edge transfers.
   task automatic tick();
      logic rs, d, v, r, b, f, l, bz;
      @(negedge clock);
      rs = reset; d = bus.dequeue_out; v = bus.bit_valid_out; r = bus.ready_in;
      b = bus.bit_out; f = bus.first_bit_out; l = bus.last_bit_out; bz = bus.busy_out;
      @(posedge clock);
      #1;
      cyc++;
      if (rs) begin
         sent.delete();
         nbits = 0;
         pending = 1'b0;
         frames_exp = 0;
         acc = '0;
      end else begin
         if (d) begin
            chk("pop_from_empty", 32'(q_model.size() != 0), 32'd1);
            if (q_model.size() != 0) sent.push_back(q_model.pop_front());
            refresh();
            deq_cnt++;
            deq_cyc.push_back(cyc);
            pending = 1'b1;
         end
         chk("bit_valid", v, pending);
         chk("first_flag", f, v && nbits == 0);
         chk("last_flag", l, v && nbits == 7);
         if (v) valid_cycles++;
         if (bz) busy_cycles++;
         if (v && r) begin
            acc = {acc[6:0], b};
            stream = {stream[62:0], b};
            nbits++;
            if (nbits == 8) begin
               if (sent.size() != 0) chk("frame_byte", acc, sent.pop_front());
               else chk("frame_without_pop", 32'(sent.size()), 32'd1);
               frames_exp++;
               nbits = 0;
               pending = 1'b0;
            end
         end
         chk("frames_out", bus.frames_out, 32'(frames_exp % 256));
      end
   endtask
   task automatic run_until_nbits(int n);
      int k = 0;
      while (nbits != n && k < 50) begin tick(); k++; end
      chk("wait_bit", nbits, n);
   endtask
   task automatic run_until_frames(int n, int cap);
      int k = 0;
      while (frames_exp < n && k < cap) begin tick(); k++; end
      chk("wait_frames", frames_exp, n);
   endtask
   initial begin
      int f0, k;
      reset = 1'b1;
      bus.enable_in = 1'b0;
      bus.ready_in = 1'b0;
      nbits = 0; frames_exp = 0; cyc = 0; pending = 1'b0; acc = '0;
      clear_stats();
      refresh();
      tick();
      tick();
      reset = 1'b0;
      chk("rst_dequeue", bus.dequeue_out, 0);
      chk("rst_bit", bus.bit_out, 0);
      chk("rst_valid", bus.bit_valid_out, 0);
      chk("rst_first", bus.first_bit_out, 0);
      chk("rst_last", bus.last_bit_out, 0);
      chk("rst_busy", bus.busy_out, 0);
      chk("rst_frames", bus.frames_out, 0);
      // single 0x52 frame, sink always ready
      clear_stats();
      bus.enable_in = 1'b1;
      bus.ready_in = 1'b1;
      push(8'h52);
      tick();
      chk("t1_dequeue", bus.dequeue_out, 1);
      chk("t1_valid", bus.bit_valid_out, 1);
      chk("t1_first", bus.first_bit_out, 1);
      chk("t1_msb", bus.bit_out, 0);
      chk("t1_busy", bus.busy_out, 1);
      run_until_frames(1, 40);
      tick();
      chk("t1_deq_cnt", deq_cnt, 1);
      chk("t1_stream", stream[7:0], 8'h52);
      chk("t1_valid_cycles", valid_cycles, 8);
      chk("t1_frames", bus.frames_out, 1);
      // same byte with a 3-cycle stall on bit 4
      clear_stats();
      push(8'h52);
      run_until_nbits(3);
      bus.ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_stall_bit", bus.bit_out, 1);
         chk("t2_stall_valid", bus.bit_valid_out, 1);
      end
      bus.ready_in = 1'b1;
      run_until_frames(2, 40);
      chk("t2_stream", stream[7:0], 8'h52);
      chk("t2_valid_cycles", valid_cycles, 11);
      // three queued bytes back to back
      clear_stats();
      push(8'hA5); push(8'hFF); push(8'h00);
      run_until_frames(5, 80);
      tick();
      tick();
      chk("t3_deq_cnt", deq_cnt, 3);
      if (deq_cyc.size() == 3) begin
         chk("t3_spacing_a", deq_cyc[1] - deq_cyc[0], 10);
         chk("t3_spacing_b", deq_cyc[2] - deq_cyc[1], 10);
      end
      chk("t3_stream", stream[23:0], 24'hA5FF00);
      chk("t3_frames", bus.frames_out, 5);
      // empty queue with enable held
      clear_stats();
      for (int i = 0; i < 20; i++) tick();
      chk("t4_deq_cnt", deq_cnt, 0);
      chk("t4_valid_cycles", valid_cycles, 0);
      chk("t4_busy_cycles", busy_cycles, 0);
      // enable dropped at bit 3: frame finishes, nothing else starts
      clear_stats();
      push(8'h81); push(8'h3C);
      run_until_nbits(2);
      bus.enable_in = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("t5_deq_cnt", deq_cnt, 1);
      chk("t5_left_in_queue", q_model.size(), 1);
      chk("t5_valid_cycles", valid_cycles, 8);
      chk("t5_stream", stream[7:0], 8'h81);
      chk("t5_busy", bus.busy_out, 0);
      q_model.delete();
      refresh();
      bus.enable_in = 1'b1;
      // reset during bit 5 aborts the frame
      push(8'h52);
      run_until_nbits(4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_dequeue", bus.dequeue_out, 0);
      chk("t6_bit", bus.bit_out, 0);
      chk("t6_valid", bus.bit_valid_out, 0);
      chk("t6_first", bus.first_bit_out, 0);
      chk("t6_last", bus.last_bit_out, 0);
      chk("t6_busy", bus.busy_out, 0);
      chk("t6_frames", bus.frames_out, 0);
      clear_stats();
      push(8'hC3);
      run_until_frames(1, 40);
      chk("t6_deq_cnt", deq_cnt, 1);
      chk("t6_stream", stream[7:0], 8'hC3);
      // frame counter wraps after 256 frames
      k = 0;
      while (frames_exp < 256 && k < 4000) begin
         if (q_model.size() < 2) push(8'($urandom));
         tick();
         k++;
      end
      chk("t7_frames_reached", frames_exp, 256);
      chk("t7_frames_wrap", bus.frames_out, 0);
      // random ready, enable and queue refills
      f0 = frames_exp;
      k = 0;
      while (frames_exp < f0 + 150 && k < 15000) begin
         bus.ready_in = ($urandom_range(0, 3) != 0);
         bus.enable_in = ($urandom_range(0, 7) != 0);
         if (q_model.size() < 8 && $urandom_range(0, 2) == 0) push(8'($urandom));
         tick();
         k++;
      end
      chk("t8_frames_reached", frames_exp, f0 + 150);
      bus.ready_in = 1'b1;
      bus.enable_in = 1'b1;
      k = 0;
      while ((q_model.size() != 0 || pending || bus.busy_out) && k < 300) begin tick(); k++; end
      chk("t8_drained", 32'(q_model.size()) + 32'(pending), 0);
      chk("t8_idle", bus.busy_out, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/queue_serializer.md
Name: queue_serializer

Overview:
- Downstream stage of the byte queue in the deserializer/queue datapath.
- Pops bytes from the 8-deep queue using its occupancy count, head data and dequeue strobe, then shifts each byte out MSB-first, one bit per accepted cycle.
- Uses a valid/ready bit handshake with the sink, plus first/last framing flags.
- Closes the loop so a byte such as 0x52 ('R') captured by the deserializer re-emerges serially.

Parameters:
- DATA_WIDTH, 8, width of a queue entry and of one serial frame.
- LEN_WIDTH, 4, width of the queue occupancy count.
- GAP_CYCLES, 1, idle cycles inserted between frames (range 1..7).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_in  input  1  permits starting a new frame.
- len_in  input  LEN_WIDTH  queue occupancy; 0 means empty.
- data_in  input  DATA_WIDTH  queue head entry; valid whenever len_in != 0.
- dequeue_out  output  1  one-cycle pop strobe to the queue.
- bit_out  output  1  current serial bit.
- bit_valid_out  output  1  bit_out is valid.
- ready_in  input  1  sink accepts bit_out this cycle.
- first_bit_out  output  1  bit_out is the MSB of the frame.
- last_bit_out  output  1  bit_out is the LSB of the frame.
- busy_out  output  1  a frame is in progress (SHIFT or GAP).
- frames_out  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- One clock (clock); reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; shift register, bit counter, gap counter and frames_out all 0.
- Reset asserted mid-frame aborts the frame. The popped byte is lost; there is no retry.
- FSM states: IDLE, SHIFT, GAP.
- IDLE -> SHIFT when enable_in == 1 and len_in != 0, evaluated at the clock edge. On that edge:
  - shift_reg <= data_in
  - bit counter <= DATA_WIDTH-1
  - dequeue_out <= 1, registered, so it is high for exactly the first SHIFT cycle.
- Queue pops at the edge ending that cycle. The head has already been latched, so dequeue-to-head latency is irrelevant.
- Pop count: exactly one dequeue_out pulse per frame. dequeue_out is never asserted when len_in == 0 was sampled.
- In SHIFT:
  - bit_valid_out = 1 and bit_out = shift_reg[MSB].
  - first_bit_out = 1 when the counter equals DATA_WIDTH-1; last_bit_out = 1 when the counter equals 0.
  - Handshake: a bit transfers on an edge where bit_valid_out && ready_in. Then shift left by 1 and decrement the counter.
  - Stall: if ready_in == 0, bit_out, the flags and the counter hold. bit_valid_out stays high; it never drops while a frame is pending.
  - Transfer of the last bit (counter 0): go to GAP, frames_out += 1 (modulo 256), load gap counter with GAP_CYCLES-1.
- GAP: bit_valid_out = 0. Counts down; at 0 go to IDLE.
  - Guarantees len_in has reflected the pop before it is sampled again.
- Back-to-back minimum period: DATA_WIDTH + GAP_CYCLES + 1 cycles per byte with ready_in held high.
- enable_in deasserted mid-frame: the current frame completes; no new frame starts.
- Queue empty in IDLE: remain in IDLE with all strobes 0.
- Simultaneous events: len_in changing while in SHIFT or GAP is ignored. Only IDLE samples len_in.
- busy_out = (state != IDLE), registered consistent with the state.

Test Plan:
- Reset then len_in=1, data_in=0x52, enable_in=1, ready_in=1 -> dequeue_out high 1 cycle; bit_out sequence 0,1,0,1,0,0,1,0 on 8 consecutive cycles; first_bit_out on bit 1; last_bit_out on bit 8; frames_out=1.
- Same byte with ready_in low for 3 cycles at bit 4 -> bit_out holds 1 with bit_valid_out=1 during the stall; total 11 valid cycles; sequence unchanged.
- len_in=3, bytes 0xA5, 0xFF, 0x00, ready_in=1 -> exactly 3 dequeue pulses spaced 10 cycles apart (GAP_CYCLES=1); serial streams match MSB-first; frames_out=3.
- len_in=0, enable_in=1 for 20 cycles -> no dequeue_out; bit_valid_out=0; busy_out=0.
- enable_in dropped at bit 3 of 0x81 with len_in=2 -> frame completes; no second dequeue_out; FSM returns to IDLE.
- reset asserted for 1 cycle at bit 5 -> next cycle all outputs 0 and state IDLE; resuming with len_in=1 starts a fresh frame from the MSB.
- 256 frames -> frames_out wraps to 0.
